// File: rtl/argmax_head.sv
// Classification head: captures a pooled activation vector, scans it LANES channels
// per cycle for the highest-scoring channel, and hands the winner over a valid/ready port.
module argmax_head #(
  parameter int NBITS  = 8,
  parameter int NFMAPS = 256,
  parameter int LANES  = 4,
  parameter int SIGNED = 0,
  parameter int IDXW   = $clog2(NFMAPS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid,
  input  logic [NFMAPS*NBITS-1:0]   input_act,
  output logic [IDXW-1:0]           class_idx,
  output logic [NBITS-1:0]          class_val,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      overrun,
  output logic [15:0]               drop_count
);

  localparam int NBEATS = NFMAPS / LANES;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0]    LAST_BEAT = BW'(NBEATS - 1);
  localparam logic [NBITS-1:0] TYPE_MIN  = (SIGNED != 0) ? {1'b1, {(NBITS-1){1'b0}}} : '0;

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t                    state;
  logic [NFMAPS*NBITS-1:0]   cap_p0;
  logic [BW-1:0]             beat;
  logic [NBITS-1:0]          best_val_p1;
  logic [IDXW-1:0]           best_idx_p1;
  logic [NBITS-1:0]          nxt_val;
  logic [IDXW-1:0]           nxt_idx;
  logic [NBITS-1:0]          cand;
  logic                      capture;
  logic                      drop;

  function automatic logic gt(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
    logic signed [NBITS-1:0] sa;
    logic signed [NBITS-1:0] sb;
    sa = a;
    sb = b;
    if (SIGNED != 0) return sa > sb;
    return a > b;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Scan stage: walk the beat's lanes in ascending order so ties keep the lowest index
  always_comb begin
    nxt_val = best_val_p1;
    nxt_idx = best_idx_p1;
    cand    = '0;
    for (int l = 0; l < LANES; l++) begin
      cand = cap_p0[(int'(beat) * LANES + l) * NBITS +: NBITS];
      if (gt(cand, nxt_val)) begin
        nxt_val = cand;
        nxt_idx = IDXW'(int'(beat) * LANES + l);
      end
    end
  end

  assign capture = valid && ((state == IDLE) || ((state == HOLD) && out_ready));
  assign drop    = valid && ((state == SCAN) || ((state == HOLD) && !out_ready));
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cap_p0      <= '0;
      beat        <= '0;
      best_val_p1 <= '0;
      best_idx_p1 <= '0;
      class_idx   <= '0;
      class_val   <= '0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
      drop_count  <= '0;
    end else begin
      overrun <= 1'b0;
      if (capture) begin
        cap_p0      <= input_act;
        beat        <= '0;
        best_val_p1 <= TYPE_MIN;
        best_idx_p1 <= '0;
      end
      case (state)
        IDLE: if (valid) state <= SCAN;
        SCAN: begin
          best_val_p1 <= nxt_val;
          best_idx_p1 <= nxt_idx;
          beat        <= beat + 1'b1;
          if (beat == LAST_BEAT) begin
            class_idx <= nxt_idx;
            class_val <= nxt_val;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= valid ? SCAN : IDLE;
        end
        default: state <= IDLE;
      endcase
      if (drop) begin
        overrun    <= 1'b1;
        drop_count <= sat_inc(drop_count);
      end
    end
  end

endmodule

// File: tb/tb_argmax_head.sv
// Bench for argmax_head: table vectors, directed handshake/overrun/reset sequences,
// and random vectors checked against a whole-vector argmax model (unsigned and signed).
module tb_argmax_head;
  localparam int NB = 8;
  localparam int NF = 256;
  localparam int LN = 4;
  localparam int LAT = NF / LN;

  typedef logic [NF*NB-1:0] vec_t;
  typedef struct {
    vec_t vec;
    int   exp_idx;
    int   exp_val;
  } vrec_t;

  logic clk = 0;
  logic rst;
  logic valid, ready;
  vec_t act;
  logic [7:0] cidx, cval;
  logic ov, busy, ovr;
  logic [15:0] dcnt;

  logic s_valid, s_ready;
  vec_t s_act;
  logic [7:0] s_cidx, s_cval;
  logic s_ov, s_busy, s_ovr;
  logic [15:0] s_dcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  argmax_head #(.NBITS(NB), .NFMAPS(NF), .LANES(LN), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .valid(valid), .input_act(act),
    .class_idx(cidx), .class_val(cval), .out_valid(ov), .out_ready(ready),
    .busy(busy), .overrun(ovr), .drop_count(dcnt));

  argmax_head #(.NBITS(NB), .NFMAPS(NF), .LANES(LN), .SIGNED(1)) u_sdut (
    .clk(clk), .rst(rst), .valid(s_valid), .input_act(s_act),
    .class_idx(s_cidx), .class_val(s_cval), .out_valid(s_ov), .out_ready(s_ready),
    .busy(s_busy), .overrun(s_ovr), .drop_count(s_dcnt));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: argmax over the whole vector, first occurrence of the maximum wins
  function automatic void ref_argmax(input vec_t v, input bit sgn, output int idx, output int val);
    int best;
    int key;
    logic [NB-1:0] x;
    best = -100000;
    idx = 0;
    val = 0;
    for (int c = 0; c < NF; c++) begin
      x = v[c*NB +: NB];
      key = sgn ? int'($signed(x)) : int'(x);
      if (key > best) begin
        best = key;
        idx = c;
        val = int'(x);
      end
    end
  endfunction

  function automatic vec_t fill(input logic [7:0] b);
    vec_t v;
    for (int c = 0; c < NF; c++) v[c*NB +: NB] = b;
    return v;
  endfunction

  function automatic vec_t rand_vec(input int hi);
    vec_t v;
    for (int c = 0; c < NF; c++) v[c*NB +: NB] = 8'($urandom_range(0, hi));
    return v;
  endfunction

  task automatic send(input vec_t v);
    @(negedge clk);
    act = v;
    valid = 1;
    @(negedge clk);
    valid = 0;
  endtask

  task automatic wait_out(input string nm, output int lat);
    lat = 0;
    while (!ov && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!ov) chk({nm, "_timeout"}, 32'(ov), 32'd1);
  endtask

  task automatic accept(input string nm);
    ready = 1;
    @(negedge clk);
    ready = 0;
    chk({nm, "_ov_fall"}, 32'(ov), 32'd0);
    chk({nm, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic run_check(input string nm, input vec_t v, input int ei, input int ev);
    int lat;
    send(v);
    wait_out(nm, lat);
    chk({nm, "_lat"}, 32'(lat), 32'(LAT));
    chk({nm, "_idx"}, 32'(cidx), 32'(ei));
    chk({nm, "_val"}, 32'(cval), 32'(ev));
  endtask

  task automatic s_run_check(input string nm, input vec_t v, input int ei, input int ev);
    int lat;
    @(negedge clk);
    s_act = v;
    s_valid = 1;
    @(negedge clk);
    s_valid = 0;
    lat = 0;
    while (!s_ov && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"}, 32'(lat), 32'(LAT));
    chk({nm, "_idx"}, 32'(s_cidx), 32'(ei));
    chk({nm, "_val"}, 32'(s_cval), 32'(ev));
    s_ready = 1;
    @(negedge clk);
    s_ready = 0;
    chk({nm, "_ov_fall"}, 32'(s_ov), 32'd0);
  endtask

  initial begin
    vrec_t tab[6];
    vec_t va, vb, vs;
    int ei, ev, ei2, ev2, lat, stall;
    bit stable;

    rst = 1; valid = 0; ready = 0; act = '0;
    s_valid = 0; s_ready = 0; s_act = '0;

    tab[0].vec = fill(8'h10); tab[0].vec[137*NB +: NB] = 8'hC8;
    tab[0].exp_idx = 137; tab[0].exp_val = 8'hC8;
    tab[1].vec = fill(8'h30);
    tab[1].vec[5*NB +: NB] = 8'hFF; tab[1].vec[6*NB +: NB] = 8'hFF; tab[1].vec[200*NB +: NB] = 8'hFF;
    tab[1].exp_idx = 5; tab[1].exp_val = 8'hFF;
    tab[2].vec = '0; tab[2].exp_idx = 0; tab[2].exp_val = 0;
    tab[3].vec = fill(8'h01); tab[3].vec[255*NB +: NB] = 8'h02;
    tab[3].exp_idx = 255; tab[3].exp_val = 2;
    tab[4].vec = fill(8'h7E); tab[4].vec[3*NB +: NB] = 8'h7F; tab[4].vec[4*NB +: NB] = 8'h7F;
    tab[4].exp_idx = 3; tab[4].exp_val = 8'h7F;
    tab[5].vec = fill(8'hAA); tab[5].exp_idx = 0; tab[5].exp_val = 8'hAA;

    repeat (3) @(negedge clk);
    chk("rst_idx", 32'(cidx), 32'd0);
    chk("rst_val", 32'(cval), 32'd0);
    chk("rst_ov", 32'(ov), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 0;
    @(negedge clk);
    chk("rst_ovr", 32'(ovr), 32'd0);
    chk("rst_dcnt", 32'(dcnt), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_check($sformatf("tab%0d", i), tab[i].vec, tab[i].exp_idx, tab[i].exp_val);
      accept($sformatf("tab%0d", i));
    end

    // Backpressure and back-to-back capture
    va = fill(8'h20); va[42*NB +: NB] = 8'h90;
    vb = rand_vec(255);
    ref_argmax(vb, 0, ei2, ev2);
    run_check("bp_a", va, 42, 8'h90);
    stable = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!(ov === 1'b1 && cidx === 8'd42 && cval === 8'h90)) stable = 0;
    end
    chk("bp_stable", 32'(stable), 32'd1);
    ready = 1; valid = 1; act = vb;
    @(negedge clk);
    ready = 0; valid = 0;
    chk("b2b_ov_fall", 32'(ov), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_out("b2b", lat);
    chk("b2b_lat", 32'(lat), 32'(LAT));
    chk("b2b_idx", 32'(cidx), 32'(ei2));
    chk("b2b_val", 32'(cval), 32'(ev2));
    chk("b2b_dcnt", 32'(dcnt), 32'd0);
    accept("b2b");

    // Overrun during SCAN
    va = fill(8'h05); va[99*NB +: NB] = 8'h66;
    send(va);
    repeat (10) @(negedge clk);
    act = fill(8'hFF); valid = 1;
    @(negedge clk);
    valid = 0;
    chk("ovr_pulse", 32'(ovr), 32'd1);
    @(negedge clk);
    chk("ovr_once", 32'(ovr), 32'd0);
    chk("ovr_dcnt", 32'(dcnt), 32'd1);
    wait_out("ovr", lat);
    chk("ovr_idx", 32'(cidx), 32'd99);
    chk("ovr_val", 32'(cval), 32'h66);

    // Saturating drop counter while parked in HOLD
    valid = 1;
    repeat (70000) @(negedge clk);
    valid = 0;
    @(negedge clk);
    chk("sat_dcnt", 32'(dcnt), 32'hFFFF);
    chk("sat_ov", 32'(ov), 32'd1);
    chk("sat_idx", 32'(cidx), 32'd99);
    accept("sat");

    // Reset mid-SCAN with a coincident valid
    send(rand_vec(255));
    repeat (30) @(negedge clk);
    rst = 1; valid = 1; act = fill(8'h11);
    @(negedge clk);
    rst = 0; valid = 0;
    chk("mrst_idx", 32'(cidx), 32'd0);
    chk("mrst_val", 32'(cval), 32'd0);
    chk("mrst_ov", 32'(ov), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_dcnt", 32'(dcnt), 32'd0);
    @(negedge clk);
    chk("mrst_stay_idle", 32'(busy), 32'd0);
    vb = rand_vec(255);
    ref_argmax(vb, 0, ei, ev);
    run_check("mrst_after", vb, ei, ev);
    accept("mrst_after");

    // Random unsigned vectors with random consumer stall
    for (int i = 0; i < 10; i++) begin
      vb = rand_vec((i % 2) ? 15 : 255);
      ref_argmax(vb, 0, ei, ev);
      run_check($sformatf("rnd%0d", i), vb, ei, ev);
      stall = $urandom_range(0, 5);
      repeat (stall) @(negedge clk);
      chk($sformatf("rnd%0d_hold", i), 32'(cidx), 32'(ei));
      accept($sformatf("rnd%0d", i));
    end

    // Signed instance
    for (int c = 0; c < NF; c++) vs[c*NB +: NB] = 8'(-128 + (c % 127));
    vs[77*NB +: NB] = 8'hFF;
    s_run_check("sgn_hot", vs, 77, 8'hFF);
    s_run_check("sgn_min", fill(8'h80), 0, 8'h80);
    for (int i = 0; i < 4; i++) begin
      vs = rand_vec(255);
      ref_argmax(vs, 1, ei, ev);
      s_run_check($sformatf("srnd%0d", i), vs, ei, ev);
    end
    chk("sgn_dcnt", 32'(s_dcnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
